// File: rtl/mips_mem_arbiter.sv
// Two-port arbiter/sequencer for the 256x32 data memory: one access at a time, registered read.
// Define MIPS_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mips_mem_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] write_data_address,
    output logic [DATA_W-1:0] write_data,
    output logic              signal_mem_write,
    output logic              signal_mem_read,
    input  logic [DATA_W-1:0] read_mem
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                arb_en;
    logic                grant_any;
    logic                grant_port;

`ifdef MIPS_ARB_RR_EN
    logic rr_q, rr_d;

    // rr_q names the favoured port when both request.
    always_comb begin
        if (p0_req && p1_req) begin
            grant_port = rr_q;
        end else begin
            grant_port = ~p0_req;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_any) begin
            rr_d = ~grant_port;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        grant_port = ~p0_req;
    end
`endif

    // Gated with rst_n so a held request cannot show a grant while in reset.
    always_comb begin
        arb_en    = (state_q == StIdle) || (state_q == StResp);
        grant_any = arb_en && (p0_req || p1_req) && rst_n;
        p0_gnt    = grant_any && !grant_port;
        p1_gnt    = grant_any && grant_port;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant_any) begin
            owner_d = grant_port;
            we_d    = grant_port ? p1_we : p0_we;
            addr_d  = grant_port ? p1_addr : p0_addr;
            wdata_d = grant_port ? p1_wdata : p0_wdata;
        end
        unique case (state_q)
            StIdle:  state_d = grant_any ? StIssue : StIdle;
            StIssue: state_d = StResp;
            StResp:  state_d = grant_any ? StIssue : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        write_data_address = addr_q;
        write_data         = wdata_q;
        signal_mem_write   = (state_q == StIssue) && we_q;
        signal_mem_read    = (state_q == StIssue) && !we_q;
        p0_ack             = (state_q == StResp) && !owner_q;
        p1_ack             = (state_q == StResp) && owner_q;
        p0_rdata           = '0;
        p1_rdata           = '0;
        if (p0_ack && !we_q) begin
            p0_rdata = read_mem;
        end
        if (p1_ack && !we_q) begin
            p1_rdata = read_mem;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: random two-port traffic against a queue-based model.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_gnt, p0_ack;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_gnt, p1_ack;
    logic [31:0] p1_rdata;
    logic [31:0] write_data_address, write_data;
    logic        signal_mem_write, signal_mem_read;
    logic [31:0] read_mem = '0;

    mips_mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .write_data_address(write_data_address), .write_data(write_data),
        .signal_mem_write(signal_mem_write), .signal_mem_read(signal_mem_read),
        .read_mem(read_mem)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT: 256 words, indexed by the low address byte, registered read.
    logic [31:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (signal_mem_write) mem[write_data_address[7:0]] <= write_data;
        if (signal_mem_read) read_mem <= mem[write_data_address[7:0]];
    end

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [256] = '{default: '0};
    int          cyc = 0;
    int          next_arb = 0;
    logic        favour = 1'b0;
    logic        mon_en = 1'b0;
    logic        e0, e1;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops completed accesses, checks memory-side issue, predicts grants.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (q.size() > 0 && q[0].ack_cyc == cyc) begin
                mon_e = q.pop_front();
                chk("p0_ack", {31'b0, p0_ack}, {31'b0, mon_e.port == 0});
                chk("p1_ack", {31'b0, p1_ack}, {31'b0, mon_e.port == 1});
                chk("p0_rdata", p0_rdata, (mon_e.port == 0 && !mon_e.we) ? mon_e.rdata : 32'h0);
                chk("p1_rdata", p1_rdata, (mon_e.port == 1 && !mon_e.we) ? mon_e.rdata : 32'h0);
            end else begin
                chk("idle_acks", {30'b0, p1_ack, p0_ack}, 32'h0);
                chk("idle_p0_rdata", p0_rdata, 32'h0);
                chk("idle_p1_rdata", p1_rdata, 32'h0);
            end
            if (q.size() > 0 && q[0].ack_cyc == cyc + 1) begin
                chk("mem_write", {31'b0, signal_mem_write}, {31'b0, q[0].we});
                chk("mem_read", {31'b0, signal_mem_read}, {31'b0, !q[0].we});
                chk("mem_addr", write_data_address, q[0].addr);
                if (q[0].we) chk("mem_wdata", write_data, q[0].wdata);
            end else begin
                chk("mem_ctrl_idle", {30'b0, signal_mem_write, signal_mem_read}, 32'h0);
            end
`ifdef MIPS_ARB_RR_EN
            e0 = (cyc >= next_arb) && p0_req && (!p1_req || !favour);
`else
            e0 = (cyc >= next_arb) && p0_req;
`endif
            e1 = (cyc >= next_arb) && p1_req && !e0;
            chk("gnt", {30'b0, p1_gnt, p0_gnt}, {30'b0, e1, e0});
            if (e0 || e1) begin
                mon_e.port    = e1 ? 1 : 0;
                mon_e.we      = e1 ? p1_we : p0_we;
                mon_e.addr    = e1 ? p1_addr : p0_addr;
                mon_e.wdata   = e1 ? p1_wdata : p0_wdata;
                mon_e.rdata   = ref_mem[mon_e.addr[7:0]];
                mon_e.ack_cyc = cyc + 2;
                if (mon_e.we) ref_mem[mon_e.addr[7:0]] = mon_e.wdata;
                q.push_back(mon_e);
                next_arb = cyc + 2;
                favour   = e0;
            end
        end
    end

    task automatic do_req(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        @(posedge clk);
        #1;
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            got = (port == 0) ? p0_gnt : p1_gnt;
        end
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout port %0d: got no grant, required a grant", port);
        end
        @(posedge clk);
        #1;
        if (port == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
    endtask

    task automatic run_port(input int port, input int n, input int maxgap);
        int          r;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            r = $urandom_range(0, 9);
            a = (r < 7) ? $urandom_range(0, 15) : (r < 9) ? $urandom_range(0, 255)
                                                          : $urandom_range(256, 4095);
            do_req(port, 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && q.size() > 0; n++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending accesses, required 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h33; p0_wdata = 32'hFFFF;
        #3;
        chk("rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h0);
        #20;
        chk("rst_gnt_after_edge", {30'b0, p1_gnt, p0_gnt}, 32'h0);
        chk("rst_acks", {30'b0, p1_ack, p0_ack}, 32'h0);
        chk("rst_ctrl", {30'b0, signal_mem_write, signal_mem_read}, 32'h0);
        chk("rst_addr", write_data_address, 32'h0);
        chk("rst_wdata", write_data, 32'h0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        do_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
        do_req(0, 1'b0, 32'd5, 32'h0);
        drain();
        do_req(1, 1'b1, 32'd200, 32'h12345678);
        do_req(0, 1'b0, 32'd200, 32'h0);
        do_req(1, 1'b1, 32'd77, 32'hCAFEF00D);
        drain();

        // Saturated contention: both ports re-request in their own ack cycle.
        fork
            run_port(0, 12, 0);
            run_port(1, 12, 0);
        join
        drain();
        fork
            run_port(0, 120, 3);
            run_port(1, 120, 2);
        join
        drain();

        // Abort a p1 write by asserting reset during its issue cycle.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd77; p1_wdata = 32'h0BADF00D;
        @(negedge clk);
        chk("abort_gnt", {31'b0, p1_gnt}, 32'h1);
        @(posedge clk);
        #1;
        p1_req = 1'b0;
        #2;
        chk("abort_issue_write", {31'b0, signal_mem_write}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_write_drop", {30'b0, signal_mem_write, signal_mem_read}, 32'h0);
        chk("abort_addr_clear", write_data_address, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        chk("abort_no_ack", {30'b0, p1_ack, p0_ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        next_arb = 0;
        favour   = 1'b0;
        mon_en   = 1'b1;
        do_req(0, 1'b0, 32'd77, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
